pcie_tlp_cpl_gen: RTL and testbench
===================================

# pcie_tlp_cpl_gen

Completion generator for the PCIe endpoint target path, downstream of the TLP request decoder. On each decoded memory-read request it:
- reads one DW from the local register/memory port;
- builds a 3DW completion TLP: CplD on success, Cpl with UR or CA status on error;
- presents the TLP on the 256-bit TX interface;
- pulses `pcie_read_ready` back to the decoder once the TLP is accepted.

## Interface
- `COMPLETER_ID`, 16'h0100: Completer ID placed in completion DW1[31:16].
- `RD_TIMEOUT`, 255: max cycles waiting for `rd_valid` before a CA completion is sent (1..4095).
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `is_read_request` in 1: one-cycle pulse from the decoder; request fields are valid in the same cycle.
- `read_addr` in 16: request byte address.
- `byte_cnt` in 12: request header DW0[11:0]; bits [9:0] are the Length field in DW.
- `bit_enable` in 4: First DW byte enables.
- `tag` in 8: request tag.
- `RequesterID` in 16: request requester ID.
- `pcie_read_ready` out 1: one-cycle pulse that releases the decoder.
- `rd_req` out 1: one-cycle read strobe to the register/memory port.
- `rd_addr` out 16: DW-aligned read address, {read_addr[15:2], 2'b00}.
- `rd_valid` in 1: read data valid.
- `rd_data` in 32: read data.
- `tx_valid` out 1: TLP valid.
- `tx_ready` in 1: TX accept.
- `tx_sop` out 1: start of packet; equals `tx_valid` (single-beat TLP).
- `tx_eop` out 1: end of packet; equals `tx_valid` (single-beat TLP).
- `tx_data` out 256: TLP beat; DW0 in [255:224], DW1 [223:192], DW2 [191:160], DW3 [159:128]; [127:0] zero.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_WAIT, TX_SEND, DONE.
- IDLE: on `is_read_request`, capture all request fields and go to:
  - RD_ISSUE if `byte_cnt[9:0]==1`;
  - TX_SEND with status UR (3'b001) otherwise.
- RD_ISSUE: `rd_req`=1 for exactly one cycle; clear the timeout counter; go to RD_WAIT.
- RD_WAIT: on `rd_valid`, capture `rd_data`, status SC (3'b000), go to TX_SEND. If the counter reaches `RD_TIMEOUT` with no `rd_valid`, status CA (3'b100), go to TX_SEND.
- TX_SEND: `tx_valid`=`tx_sop`=`tx_eop`=1; `tx_data` held stable until `tx_valid&tx_ready`, then go to DONE.
- DONE: `pcie_read_ready`=1 for one cycle; go to IDLE.
- CplD (status SC) fields:
  - DW0 = 32'h4A000001.
  - DW1 = {COMPLETER_ID, 3'b000, 1'b0, bytecount[11:0]}.
  - DW2 = {RequesterID, tag, 1'b0, lower_addr[6:0]}.
  - DW3 = captured `rd_data`.
- Cpl (UR/CA) fields:
  - DW0 = 32'h0A000000.
  - DW1 = {COMPLETER_ID, status, 1'b0, 12'h004}.
  - DW2 = {RequesterID, tag, 8'h00}.
  - DW3 = 0.
- bytecount from `bit_enable`:
  - 1xx1 → 4.
  - 01x1 or 1x10 → 3.
  - 0011, 0110, 1100 → 2.
  - Any other value (including 0000) → 1.
- lower_addr = {read_addr[6:2], lsb}. lsb by lowest set BE bit: xxx1→00, xx10→01, x100→10, 1000→11, 0000→00.
- `is_read_request` outside IDLE is ignored. `rd_valid` outside RD_WAIT is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, captured fields and counter 0. Reset mid-transaction aborts it: no TLP and no `pcie_read_ready` after release.
- Request pulse at cycle T → `rd_req` at T+1.
- `rd_valid` at cycle R → `tx_valid` at R+1.
- Zero-wait read (`rd_valid` at T+2) → `tx_valid` at T+3.
- UR path: `tx_valid` at T+1.
- Handshake at cycle H → `pcie_read_ready` at H+1; IDLE at H+2. A new request is accepted from H+2.
- Timeout: counter increments each RD_WAIT cycle. CA `tx_valid` appears `RD_TIMEOUT`+1 cycles after entering RD_WAIT.
- `rd_valid` in the same cycle the timeout expires: `rd_valid` wins, status SC.
- `tx_valid` never deasserts before acceptance; `tx_data` must not change while `tx_valid`=1 and `tx_ready`=0.

## Test plan
- **Basic read.** Request with read_addr=16'h0014, len 1, BE=4'hF, tag=8'h21, RequesterID=16'h0000; `rd_data`=32'hDEADBEEF after 1 cycle; `tx_ready`=1.
  - `rd_addr`=16'h0014.
  - TLP DW0..DW3 = 4A000001, 01000004, 00002114, DEADBEEF.
  - `pcie_read_ready` pulses once.
- **BE decode.** BE=4'b0110, read_addr=16'h0008.
  - DW1[11:0]=2.
  - DW2[6:0]=7'h09.
- **Unsupported length.** `byte_cnt`=12'h002.
  - No `rd_req`.
  - DW0=0A000000, DW1=0100_2004.
  - `tx_valid` at T+1.
- **Read timeout.** `RD_TIMEOUT`=8, `rd_valid` never asserted.
  - CA completion with DW1=0100_8004.
  - `tx_valid` exactly 9 cycles after entering RD_WAIT.
- **Backpressure.** `tx_ready` low for 5 cycles.
  - `tx_data`/`tx_sop`/`tx_eop` stable throughout.
  - Single `pcie_read_ready` one cycle after acceptance.
  - A second `is_read_request` pulse during TX_SEND is ignored.
- **Reset in RD_WAIT.** Assert `rstn` low in RD_WAIT.
  - All outputs 0.
  - After release, a late `rd_valid` produces no TLP.

Source files
------------

// File: rtl/pcie_tlp_cpl_gen.sv
// Completion generator: one DW memory read -> 3DW CplD (SC) or Cpl (UR/CA) on a 256-bit TX beat.
// Latency: rd_req 1 cycle after request; TLP 1 cycle after rd_valid (UR: 1 cycle after request).
// Backpressure: TLP held stable until tx_ready; decoder stays blocked until pcie_read_ready pulses.
module pcie_tlp_cpl_gen #(
  parameter logic [15:0] COMPLETER_ID = 16'h0100,
  parameter int unsigned RD_TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         is_read_request,
  input  logic [15:0]  read_addr,
  input  logic [11:0]  byte_cnt,
  input  logic [3:0]   bit_enable,
  input  logic [7:0]   tag,
  input  logic [15:0]  RequesterID,
  output logic         pcie_read_ready,
  output logic         rd_req,
  output logic [15:0]  rd_addr,
  input  logic         rd_valid,
  input  logic [31:0]  rd_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_sop,
  output logic         tx_eop,
  output logic [255:0] tx_data
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    TX_SEND  = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [2:0]  ST_SC       = 3'b000;
  localparam logic [2:0]  ST_UR       = 3'b001;
  localparam logic [2:0]  ST_CA       = 3'b100;
  localparam logic [11:0] TIMEOUT_CNT = 12'(RD_TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [13:0] r_addr;     // DW address, read_addr[15:2]
  logic [3:0]  r_be;
  logic [7:0]  r_tag;
  logic [15:0] r_rid;
  logic [2:0]  r_status;
  logic [31:0] r_data;
  logic [11:0] r_cnt;

  logic        w_len_ok;
  logic        w_timeout;
  logic [11:0] w_bytecount;
  logic [1:0]  w_lsb;
  logic        w_unused;

  // Only single-DW reads are served; byte offset bits come from the byte enables instead.
  assign w_len_ok  = (byte_cnt[9:0] == 10'd1);
  assign w_timeout = (r_cnt == TIMEOUT_CNT);
  assign w_unused  = ^{byte_cnt[11:10], read_addr[1:0]};
  assign rd_addr   = {r_addr, 2'b00};

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control outputs decoded from the current state
  always_comb begin
    w_state_nxt     = r_state;
    rd_req          = 1'b0;
    tx_valid        = 1'b0;
    tx_sop          = 1'b0;
    tx_eop          = 1'b0;
    pcie_read_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (is_read_request) begin
          w_state_nxt = w_len_ok ? RD_ISSUE : TX_SEND;
        end
      end
      RD_ISSUE: begin
        rd_req      = 1'b1;
        w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_valid || w_timeout) begin
          w_state_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_valid = 1'b1;
        tx_sop   = 1'b1;
        tx_eop   = 1'b1;
        if (tx_ready) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        pcie_read_ready = 1'b1;
        w_state_nxt     = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request capture, read-data capture, completion status and read timeout counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr   <= '0;
      r_be     <= '0;
      r_tag    <= '0;
      r_rid    <= '0;
      r_status <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (is_read_request) begin
            r_addr   <= read_addr[15:2];
            r_be     <= bit_enable;
            r_tag    <= tag;
            r_rid    <= RequesterID;
            r_status <= w_len_ok ? ST_SC : ST_UR;
          end
        end
        RD_ISSUE: begin
          r_cnt <= '0;
        end
        RD_WAIT: begin
          // Data arriving on the expiry cycle still counts as a successful read.
          if (rd_valid) begin
            r_data   <= rd_data;
            r_status <= ST_SC;
          end else if (w_timeout) begin
            r_status <= ST_CA;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Byte count and low address offset derived from the first-DW byte enables
  always_comb begin
    w_bytecount = 12'd1;
    w_lsb       = 2'b00;
    casez (r_be)
      4'b1??1:                    w_bytecount = 12'd4;
      4'b01?1, 4'b1?10:           w_bytecount = 12'd3;
      4'b0011, 4'b0110, 4'b1100:  w_bytecount = 12'd2;
      default:                    w_bytecount = 12'd1;
    endcase
    casez (r_be)
      4'b???1: w_lsb = 2'b00;
      4'b??10: w_lsb = 2'b01;
      4'b?100: w_lsb = 2'b10;
      4'b1000: w_lsb = 2'b11;
      default: w_lsb = 2'b00;
    endcase
  end

  // Completion beat; driven only while the TLP is offered so idle outputs read zero
  always_comb begin
    tx_data = '0;
    if (r_state == TX_SEND) begin
      if (r_status == ST_SC) begin
        tx_data = {32'h4A000001,
                   COMPLETER_ID, 3'b000, 1'b0, w_bytecount,
                   r_rid, r_tag, 1'b0, r_addr[4:0], w_lsb,
                   r_data,
                   128'h0};
      end else begin
        tx_data = {32'h0A000000,
                   COMPLETER_ID, r_status, 1'b0, 12'h004,
                   r_rid, r_tag, 8'h00,
                   32'h0,
                   128'h0};
      end
    end
  end

endmodule

// File: tb/tb_pcie_tlp_cpl_gen.sv
// Bench for pcie_tlp_cpl_gen: scoreboarded completions, latency, timeout, backpressure, reset abort.
// Latency: not applicable.
// Backpressure: tx_ready driven by the bench.
module tb_pcie_tlp_cpl_gen;

  localparam logic [15:0] CID = 16'h0100;
  localparam int          TMO = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         is_read_request = 1'b0;
  logic [15:0]  read_addr = '0;
  logic [11:0]  byte_cnt = '0;
  logic [3:0]   bit_enable = '0;
  logic [7:0]   tag = '0;
  logic [15:0]  RequesterID = '0;
  logic         pcie_read_ready;
  logic         rd_req;
  logic [15:0]  rd_addr;
  logic         rd_valid = 1'b0;
  logic [31:0]  rd_data = '0;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic         tx_sop;
  logic         tx_eop;
  logic [255:0] tx_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_rdreq = 0;
  int n_prdy = 0;
  int n_hs = 0;
  logic [255:0] exp_q [$];

  pcie_tlp_cpl_gen #(.COMPLETER_ID(CID), .RD_TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .is_read_request(is_read_request), .read_addr(read_addr), .byte_cnt(byte_cnt),
    .bit_enable(bit_enable), .tag(tag), .RequesterID(RequesterID),
    .pcie_read_ready(pcie_read_ready), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_data(tx_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rd_req) n_rdreq <= n_rdreq + 1;
    if (pcie_read_ready) n_prdy <= n_prdy + 1;
    if (tx_valid && tx_ready) n_hs <= n_hs + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference completion: byte count is the span from lowest to highest enabled byte.
  function automatic logic [255:0] model(input logic [2:0] st, input logic [15:0] a,
                                         input logic [3:0] be, input logic [7:0] tg,
                                         input logic [15:0] rid, input logic [31:0] d);
    int first;
    int last;
    logic [11:0] bc;
    logic [1:0]  lsb;
    first = -1;
    last  = -1;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        if (first < 0) first = i;
        last = i;
      end
    end
    if (first < 0) begin
      bc  = 12'd1;
      lsb = 2'd0;
    end else begin
      bc  = 12'(last - first + 1);
      lsb = 2'(first);
    end
    if (st == 3'b000)
      return {32'h4A000001, CID, 3'b000, 1'b0, bc, rid, tg, 1'b0, a[6:2], lsb, d, 128'h0};
    return {32'h0A000000, CID, st, 1'b0, 12'h004, rid, tg, 8'h00, 32'h0, 128'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [15:0] a, input logic [11:0] len, input logic [3:0] be,
                          input logic [7:0] tg, input logic [15:0] rid, output int t);
    is_read_request = 1'b1;
    read_addr       = a;
    byte_cnt        = len;
    bit_enable      = be;
    tag             = tg;
    RequesterID     = rid;
    t               = cyc;
    tick();
    is_read_request = 1'b0;
    read_addr       = '0;
    byte_cnt        = '0;
    bit_enable      = '0;
    tag             = '0;
    RequesterID     = '0;
  endtask

  // Runs one request with tx_ready high; dly<0 means the read port never answers.
  // Returns at the first cycle a new request may be accepted.
  task automatic do_read(input logic [15:0] a, input logic [11:0] len, input logic [3:0] be,
                         input logic [7:0] tg, input logic [15:0] rid, input logic [31:0] d,
                         input int dly, output logic [255:0] obs, output logic [15:0] addr_seen,
                         output logic [1:0] sopeop, output int lat, output bit got);
    int t;
    int w;
    send_req(a, len, be, tg, rid, t);
    addr_seen = rd_addr;
    if (len[9:0] == 10'd1 && dly >= 0) begin
      tick();
      repeat (dly) tick();
      rd_valid = 1'b1;
      rd_data  = d;
      tick();
      rd_valid = 1'b0;
      rd_data  = '0;
    end
    w = 0;
    while (!tx_valid && w < 60) begin
      tick();
      w++;
    end
    got    = tx_valid;
    obs    = tx_data;
    sopeop = {tx_sop, tx_eop};
    lat    = cyc - t;
    if (got) begin
      tick();
      tick();
    end
  endtask

  task automatic test_reset();
    logic [277:0] outs;
    repeat (3) tick();
    outs = {tx_valid, tx_sop, tx_eop, rd_req, pcie_read_ready, rd_addr, tx_data};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_held: outputs=%h required=0", outs);
    end
    rstn = 1'b1;
    repeat (2) tick();
    outs = {tx_valid, tx_sop, tx_eop, rd_req, pcie_read_ready, rd_addr, tx_data};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_release: outputs=%h required=0", outs);
    end
  endtask

  task automatic test_basic_read();
    logic [255:0] obs, e;
    logic [15:0]  as;
    logic [1:0]   se;
    int lat, r0, p0, h0;
    bit got;
    r0 = n_rdreq; p0 = n_prdy; h0 = n_hs;
    exp_q.push_back(model(3'b000, 16'h0014, 4'hF, 8'h21, 16'h0000, 32'hDEADBEEF));
    do_read(16'h0014, 12'h001, 4'hF, 8'h21, 16'h0000, 32'hDEADBEEF, 0, obs, as, se, lat, got);
    e = exp_q.pop_front();
    checks++;
    if (as !== 16'h0014) begin failures++; $display("FAIL basic_rd_addr: got %h required 0014", as); end
    checks++;
    if (!got || lat != 3) begin failures++; $display("FAIL basic_latency: got=%0d lat=%0d required lat 3", got, lat); end
    checks++;
    if (obs !== e) begin failures++; $display("FAIL basic_tlp: got %h required %h", obs, e); end
    checks++;
    if (obs[255:128] !== 128'h4A000001_01000004_00002114_DEADBEEF) begin
      failures++; $display("FAIL basic_dwords: got %h", obs[255:128]);
    end
    checks++;
    if (se !== 2'b11) begin failures++; $display("FAIL basic_sop_eop: got %b required 11", se); end
    checks++;
    if (n_rdreq - r0 != 1 || n_prdy - p0 != 1 || n_hs - h0 != 1) begin
      failures++;
      $display("FAIL basic_pulses: rd_req=%0d ready=%0d handshakes=%0d required 1 each",
               n_rdreq - r0, n_prdy - p0, n_hs - h0);
    end
  endtask

  task automatic test_be_decode();
    logic [3:0]   be_tab [0:6];
    logic [255:0] obs, e;
    logic [15:0]  as, a;
    logic [1:0]   se;
    int lat;
    bit got;
    be_tab = '{4'b0110, 4'b0101, 4'b1010, 4'b0000, 4'b1000, 4'b1001, 4'b0100};
    for (int i = 0; i < 7; i++) begin
      a = (i == 0) ? 16'h0008 : 16'(16'h1234 + i * 20);
      exp_q.push_back(model(3'b000, a, be_tab[i], 8'(i + 5), 16'hABCD, 32'h12345678 + i));
      do_read(a, 12'h001, be_tab[i], 8'(i + 5), 16'hABCD, 32'h12345678 + i, i % 3, obs, as, se, lat, got);
      e = exp_q.pop_front();
      checks++;
      if (!got || lat != 3 + i % 3 || obs !== e) begin
        failures++;
        $display("FAIL be_decode[%0d]: got=%0d lat=%0d tlp=%h required lat %0d tlp=%h",
                 i, got, lat, obs, 3 + i % 3, e);
      end
      checks++;
      if (as !== {a[15:2], 2'b00}) begin failures++; $display("FAIL be_rd_addr[%0d]: got %h", i, as); end
      if (i == 0) begin
        checks++;
        if (obs[203:192] !== 12'd2 || obs[166:160] !== 7'h09) begin
          failures++;
          $display("FAIL be_0110: bytecount=%h lower_addr=%h required 002 09", obs[203:192], obs[166:160]);
        end
      end
    end
  endtask

  task automatic test_unsupported_len();
    logic [255:0] obs, e;
    logic [15:0]  as;
    logic [1:0]   se;
    int lat, r0;
    bit got;
    r0 = n_rdreq;
    exp_q.push_back(model(3'b001, 16'h0040, 4'hF, 8'h33, 16'h1234, 32'h0));
    do_read(16'h0040, 12'h002, 4'hF, 8'h33, 16'h1234, 32'h0, 0, obs, as, se, lat, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || lat != 1) begin failures++; $display("FAIL ur_latency: got=%0d lat=%0d required 1", got, lat); end
    checks++;
    if (obs !== e) begin failures++; $display("FAIL ur_tlp: got %h required %h", obs, e); end
    checks++;
    if (obs[255:192] !== 64'h0A000000_01002004) begin failures++; $display("FAIL ur_dw01: got %h", obs[255:192]); end
    exp_q.push_back(model(3'b001, 16'h0100, 4'h1, 8'h34, 16'h4321, 32'h0));
    do_read(16'h0100, 12'h000, 4'h1, 8'h34, 16'h4321, 32'h0, 0, obs, as, se, lat, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || lat != 1 || obs !== e) begin
      failures++; $display("FAIL ur_len0: got=%0d lat=%0d tlp=%h required %h", got, lat, obs, e);
    end
    checks++;
    if (n_rdreq != r0) begin failures++; $display("FAIL ur_no_rd_req: rd_req pulses=%0d required 0", n_rdreq - r0); end
  endtask

  task automatic test_timeout();
    logic [255:0] obs, e;
    logic [15:0]  as;
    logic [1:0]   se;
    int lat, p0;
    bit got;
    p0 = n_prdy;
    exp_q.push_back(model(3'b100, 16'h0200, 4'hF, 8'h44, 16'h00AA, 32'h0));
    do_read(16'h0200, 12'h001, 4'hF, 8'h44, 16'h00AA, 32'h0, -1, obs, as, se, lat, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || lat != TMO + 3) begin
      failures++; $display("FAIL timeout_latency: got=%0d lat=%0d required %0d", got, lat, TMO + 3);
    end
    checks++;
    if (obs !== e || obs[223:192] !== 32'h01008004) begin
      failures++; $display("FAIL timeout_tlp: got %h required %h", obs, e);
    end
    checks++;
    if (n_prdy - p0 != 1) begin failures++; $display("FAIL timeout_ready: pulses=%0d required 1", n_prdy - p0); end
    // rd_valid on the expiry cycle must win
    exp_q.push_back(model(3'b000, 16'h0204, 4'h3, 8'h45, 16'h00AB, 32'hCAFEF00D));
    do_read(16'h0204, 12'h001, 4'h3, 8'h45, 16'h00AB, 32'hCAFEF00D, TMO, obs, as, se, lat, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || lat != TMO + 3 || obs !== e) begin
      failures++; $display("FAIL timeout_race: got=%0d lat=%0d tlp=%h required %h", got, lat, obs, e);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] held, e;
    int t, h, r0, p0, h0;
    r0 = n_rdreq; p0 = n_prdy; h0 = n_hs;
    tx_ready = 1'b0;
    exp_q.push_back(model(3'b000, 16'h0300, 4'hC, 8'h55, 16'h0F0F, 32'hA5A5_5A5A));
    send_req(16'h0300, 12'h001, 4'hC, 8'h55, 16'h0F0F, t);
    tick();
    rd_valid = 1'b1;
    rd_data  = 32'hA5A5_5A5A;
    tick();
    rd_valid = 1'b0;
    rd_data  = '0;
    held = tx_data;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({tx_valid, tx_sop, tx_eop} !== 3'b111 || tx_data !== held) begin
        failures++;
        $display("FAIL bp_stable[%0d]: vld/sop/eop=%b data=%h held=%h", k, {tx_valid, tx_sop, tx_eop}, tx_data, held);
      end
      if (k == 1) begin
        is_read_request = 1'b1; read_addr = 16'h0400; byte_cnt = 12'h001;
        bit_enable = 4'hF; tag = 8'h66; RequesterID = 16'h7777;
      end
      tick();
      is_read_request = 1'b0; read_addr = '0; byte_cnt = '0;
      bit_enable = '0; tag = '0; RequesterID = '0;
    end
    tx_ready = 1'b1;
    h = cyc;
    e = exp_q.pop_front();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== e || h - t != 8) begin
      failures++; $display("FAIL bp_accept: vld=%b at +%0d data=%h required %h", tx_valid, h - t, tx_data, e);
    end
    tick();
    checks++;
    if (pcie_read_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_pulse: got %b required 1", pcie_read_ready); end
    tick();
    checks++;
    if (pcie_read_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_single: got %b required 0", pcie_read_ready); end
    repeat (6) tick();
    checks++;
    if (n_rdreq - r0 != 1 || n_prdy - p0 != 1 || n_hs - h0 != 1 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_ignored_req: rd_req=%0d ready=%0d handshakes=%0d vld=%b required 1 1 1 0",
               n_rdreq - r0, n_prdy - p0, n_hs - h0, tx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] obs, e;
    logic [15:0]  as, a;
    logic [1:0]   se;
    logic [31:0]  d;
    int lat, p0;
    bit got;
    p0 = n_prdy;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom_range(0, 16'hFFFF));
      d = $urandom;
      if (i == 1) begin
        exp_q.push_back(model(3'b001, a, 4'hF, 8'(8'h70 + i), 16'h2222, 32'h0));
        do_read(a, 12'h010, 4'hF, 8'(8'h70 + i), 16'h2222, d, 0, obs, as, se, lat, got);
      end else begin
        exp_q.push_back(model(3'b000, a, 4'hF, 8'(8'h70 + i), 16'h2222, d));
        do_read(a, 12'h401, 4'hF, 8'(8'h70 + i), 16'h2222, d, 0, obs, as, se, lat, got);
      end
      e = exp_q.pop_front();
      checks++;
      if (!got || lat != ((i == 1) ? 1 : 3) || obs !== e) begin
        failures++; $display("FAIL b2b[%0d]: got=%0d lat=%0d tlp=%h required %h", i, got, lat, obs, e);
      end
    end
    checks++;
    if (n_prdy - p0 != 3) begin failures++; $display("FAIL b2b_ready: pulses=%0d required 3", n_prdy - p0); end
  endtask

  task automatic test_reset_mid();
    logic [277:0] outs;
    int t, p0, h0;
    send_req(16'h0500, 12'h001, 4'hF, 8'h99, 16'h3333, t);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    outs = {tx_valid, tx_sop, tx_eop, rd_req, pcie_read_ready, rd_addr, tx_data};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL rst_mid_outputs: outputs=%h required 0", outs); end
    p0 = n_prdy; h0 = n_hs;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    rd_valid = 1'b1;
    rd_data  = 32'h0BAD_0BAD;
    tick();
    rd_valid = 1'b0;
    rd_data  = '0;
    repeat (15) tick();
    checks++;
    if (n_hs != h0 || n_prdy != p0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_no_tlp: handshakes=%0d ready=%0d vld=%b required 0 0 0", n_hs - h0, n_prdy - p0, tx_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_be_decode();
    test_unsupported_len();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_basic_read();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
